// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle: unit result ports plus the retire valid/ready handshake.
interface wb_arbiter_if #(
   parameter int NUM_UNITS = 4,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 3
);
   localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [NUM_UNITS-1:0]        unit_done;
   logic [NUM_UNITS*DATA_W-1:0] unit_rd;
   logic [NUM_UNITS*ID_W-1:0]   unit_id;
   logic [NUM_UNITS-1:0]        unit_ack;
   logic                        retire_valid;
   logic                        retire_ready;
   logic [DATA_W-1:0]           retire_data;
   logic [ID_W-1:0]             retire_id;
   logic [UW-1:0]               retire_unit;

   // Arbiter side.
   modport master (
      input  unit_done, unit_rd, unit_id, retire_ready,
      output unit_ack, retire_valid, retire_data, retire_id, retire_unit
   );

   // Units and commit stage side.
   modport slave (
      output unit_done, unit_rd, unit_id, retire_ready,
      input  unit_ack, retire_valid, retire_data, retire_id, retire_unit
   );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: grants one done unit per cycle into a
// registered retire slot drained by a valid/ready handshake.
module wb_arbiter #(
   parameter int NUM_UNITS = 4,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 3
) (
   input logic          clk,
   input logic          rst,
   wb_arbiter_if.master bus
);
   localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [DATA_W-1:0]    w_rd_arr [NUM_UNITS];
   logic [ID_W-1:0]      w_id_arr [NUM_UNITS];
   logic                 w_found;
   logic [UW-1:0]        w_gidx;
   logic                 w_slot_free;
   logic                 w_ack_en;
   logic [NUM_UNITS-1:0] w_ack;

   logic                 r_valid;
   logic [DATA_W-1:0]    r_data;
   logic [ID_W-1:0]      r_id;
   logic [UW-1:0]        r_unit;
   logic [UW-1:0]        r_rr_ptr;

   for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
      assign w_rd_arr[g] = bus.unit_rd[g*DATA_W +: DATA_W];
      assign w_id_arr[g] = bus.unit_id[g*ID_W +: ID_W];
   end

   // Scan from the round-robin pointer with wraparound; first done unit wins.
   always_comb begin
      logic [UW:0] v_sum;
      v_sum   = '0;
      w_found = 1'b0;
      w_gidx  = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         v_sum = {1'b0, r_rr_ptr} + (UW+1)'(k);
         if (v_sum >= (UW+1)'(NUM_UNITS)) begin
            v_sum = v_sum - (UW+1)'(NUM_UNITS);
         end
         if (!w_found && bus.unit_done[v_sum[UW-1:0]]) begin
            w_found = 1'b1;
            w_gidx  = v_sum[UW-1:0];
         end
      end
   end

   assign w_slot_free = ~r_valid | bus.retire_ready;
   assign w_ack_en    = w_found & w_slot_free & ~rst;
   assign w_ack       = w_ack_en ? (NUM_UNITS'(1) << w_gidx) : '0;

   // Retire slot: load on grant (same-edge pass-through when popping), clear on pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_id     <= '0;
         r_unit   <= '0;
         r_rr_ptr <= '0;
      end else if (w_ack_en) begin
         r_valid  <= 1'b1;
         r_data   <= w_rd_arr[w_gidx];
         r_id     <= w_id_arr[w_gidx];
         r_unit   <= w_gidx;
         r_rr_ptr <= (w_gidx == UW'(NUM_UNITS - 1)) ? '0 : w_gidx + UW'(1);
      end else if (r_valid && bus.retire_ready) begin
         r_valid  <= 1'b0;
      end
   end

   assign bus.unit_ack     = w_ack;
   assign bus.retire_valid = r_valid;
   assign bus.retire_data  = r_data;
   assign bus.retire_id    = r_id;
   assign bus.retire_unit  = r_unit;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by a randomized run
// against a queue-based reference model.
module tb_wb_arbiter;
   localparam int NU = 4;
   localparam int DW = 32;
   localparam int IW = 3;
   localparam int UW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_arbiter_if #(.NUM_UNITS(NU), .DATA_W(DW), .ID_W(IW)) bus ();

   wb_arbiter #(.NUM_UNITS(NU), .DATA_W(DW), .ID_W(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [UW-1:0] u;
      logic [IW-1:0] id;
      logic [DW-1:0] d;
   } ent_t;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [NU-1:0] busy;
   logic [DW-1:0] cur_rd [NU];
   logic [IW-1:0] cur_id [NU];
   int            waited [NU];
   ent_t          sb [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      bus.unit_done = busy;
      for (int i = 0; i < NU; i++) begin
         bus.unit_rd[i*DW +: DW] = cur_rd[i];
         bus.unit_id[i*IW +: IW] = cur_id[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_unit(input int i, input logic [DW-1:0] d, input logic [IW-1:0] id);
      busy[i]   = 1'b1;
      cur_rd[i] = d;
      cur_id[i] = id;
   endtask

   initial begin
      int            ptr;
      int            g;
      int            u;
      bit            found;
      bit            expv;
      logic [NU-1:0] ack_exp;
      int unsigned   seq;
      ent_t          e;

      rst = 1'b1;
      busy = '0;
      bus.retire_ready = 1'b0;
      for (int i = 0; i < NU; i++) begin
         cur_rd[i] = '0;
         cur_id[i] = '0;
         waited[i] = 0;
      end
      drive();

      // Reset behaviour: no acks while rst high, slot cleared.
      @(negedge clk);
      busy = '1;
      drive();
      #1 chk("ack_in_rst", 64'(bus.unit_ack), 0);
      tick();
      #1;
      chk("rst_valid", 64'(bus.retire_valid), 0);
      chk("rst_data", 64'(bus.retire_data), 0);
      chk("rst_id", 64'(bus.retire_id), 0);
      chk("rst_unit", 64'(bus.retire_unit), 0);
      chk("rst_ack", 64'(bus.unit_ack), 0);

      // Single result from unit 1.
      rst = 1'b0;
      busy = '0;
      set_unit(1, 32'h0000_00AB, 3'd5);
      bus.retire_ready = 1'b1;
      drive();
      #1 chk("t1_ack", 64'(bus.unit_ack), 64'h2);
      tick();
      busy = '0;
      drive();
      #1;
      chk("t1_valid", 64'(bus.retire_valid), 1);
      chk("t1_data", 64'(bus.retire_data), 64'hAB);
      chk("t1_id", 64'(bus.retire_id), 5);
      chk("t1_unit", 64'(bus.retire_unit), 1);
      chk("t1_ack0", 64'(bus.unit_ack), 0);
      tick();
      #1;
      chk("t1_drop", 64'(bus.retire_valid), 0);
      chk("t1_stable", 64'(bus.retire_data), 64'hAB);

      // Round-robin with all units done from reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NU; i++) set_unit(i, DW'(32'h100 + i), IW'(i));
      for (int c = 0; c < 5; c++) begin
         drive();
         #1 chk("t2_ack", 64'(bus.unit_ack), 64'(1) << (c % NU));
         if (c >= 1) begin
            chk("t2_valid", 64'(bus.retire_valid), 1);
            chk("t2_unit", 64'(bus.retire_unit), 64'(c - 1));
         end
         tick();
      end
      busy = '0;
      bus.retire_ready = 1'b0;
      drive();
      #1 chk("t2_last", 64'(bus.retire_unit), 0);
      tick();

      // Backpressure: slot full, unit 2 waits.
      set_unit(2, 32'h2222, 3'd2);
      for (int c = 0; c < 3; c++) begin
         drive();
         #1;
         chk("t3_ack0", 64'(bus.unit_ack), 0);
         chk("t3_valid", 64'(bus.retire_valid), 1);
         chk("t3_hold", 64'(bus.retire_unit), 0);
         chk("t3_hold_d", 64'(bus.retire_data), 64'h100);
         tick();
      end
      bus.retire_ready = 1'b1;
      drive();
      #1 chk("t3_ack", 64'(bus.unit_ack), 64'h4);
      tick();
      busy = '0;
      drive();
      #1;
      chk("t3_valid2", 64'(bus.retire_valid), 1);
      chk("t3_unit", 64'(bus.retire_unit), 2);
      chk("t3_data", 64'(bus.retire_data), 64'h2222);

      // Pass-through: pop and load on the same edge.
      set_unit(3, 32'h3333, 3'd3);
      drive();
      #1 chk("t4_ack", 64'(bus.unit_ack), 64'h8);
      tick();
      busy = '0;
      drive();
      #1;
      chk("t4_valid", 64'(bus.retire_valid), 1);
      chk("t4_unit", 64'(bus.retire_unit), 3);
      chk("t4_data", 64'(bus.retire_data), 64'h3333);
      tick();
      #1 chk("t4_empty", 64'(bus.retire_valid), 0);

      // Reset mid-operation.
      bus.retire_ready = 1'b0;
      set_unit(1, 32'h6666, 3'd6);
      drive();
      #1 chk("t5_ack1", 64'(bus.unit_ack), 64'h2);
      tick();
      busy = '0;
      drive();
      #1 chk("t5_id", 64'(bus.retire_id), 6);
      rst = 1'b1;
      set_unit(0, 32'hA0, 3'd0);
      set_unit(2, 32'hA2, 3'd2);
      drive();
      #1 chk("t5_ack_rst", 64'(bus.unit_ack), 0);
      tick();
      rst = 1'b0;
      bus.retire_ready = 1'b1;
      #1;
      chk("t5_valid", 64'(bus.retire_valid), 0);
      chk("t5_ptr0", 64'(bus.unit_ack), 64'h1);
      tick();
      busy[0] = 1'b0;
      drive();
      #1;
      chk("t5_unit", 64'(bus.retire_unit), 0);
      chk("t5_next", 64'(bus.unit_ack), 64'h4);
      tick();
      busy = '0;
      drive();
      tick();
      tick();

      // Randomized run against the reference model, then drain.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ptr = 0;
      seq = 0;
      sb.delete();
      for (int cyc = 0; cyc < 10040; cyc++) begin
         for (int i = 0; i < NU; i++) begin
            if (cyc < 10000 && !busy[i] && $urandom_range(0, 2) == 0) begin
               seq++;
               set_unit(i, {8'(i), seq[23:0]}, IW'($urandom));
               waited[i] = 0;
            end
         end
         bus.retire_ready = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 9) < 7);
         drive();
         #1;
         // Grant = done unit at smallest circular distance from the pointer.
         found = 0;
         g = 0;
         for (int d = 0; d < NU; d++) begin
            u = (ptr + d) % NU;
            if (!found && busy[u]) begin
               found = 1;
               g = u;
            end
         end
         expv = (sb.size() != 0);
         ack_exp = (found && (!expv || bus.retire_ready)) ? NU'(1) << g : '0;
         chk("r_valid", 64'(bus.retire_valid), 64'(expv));
         chk("r_ack", 64'(bus.unit_ack), 64'(ack_exp));
         chk("r_onehot", 64'($countones(bus.unit_ack) <= 1), 1);
         if (expv && bus.retire_ready) begin
            e = sb.pop_front();
            chk("r_data", 64'(bus.retire_data), 64'(e.d));
            chk("r_id", 64'(bus.retire_id), 64'(e.id));
            chk("r_unit", 64'(bus.retire_unit), 64'(e.u));
         end
         if (ack_exp != '0) begin
            for (int i = 0; i < NU; i++) if (busy[i]) waited[i]++;
            chk("r_fair", 64'(waited[g] <= NU), 1);
            e.u = UW'(g);
            e.id = cur_id[g];
            e.d = cur_rd[g];
            sb.push_back(e);
            busy[g] = 1'b0;
            ptr = (g + 1) % NU;
         end
         tick();
      end
      chk("drain_busy", 64'(busy), 0);
      chk("drain_sb", 64'(sb.size()), 0);
      chk("drain_valid", 64'(bus.retire_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
